pc_sequencer: RTL

//  Owns the architectural PC and sequences one instruction at a time: fetch, issue to decode,

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_sequencer_fetch_timer.sv | 32 +++
 rtl/pc_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the PC sequencer: FSM state encoding and the
// timer width used by the fetch watchdog.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      PCS_FETCH   = 2'd0,
      PCS_ISSUE   = 2'd1,
      PCS_RESOLVE = 2'd2,
      PCS_TRAP    = 2'd3
   } pcsState_e;

   localparam int          TIMER_W = 8;
   localparam logic [31:0] PC_STEP = 32'd4;

   function automatic logic isWordAligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pc_sequencer_fetch_timer.sv
// Watchdog for outstanding instruction fetches: counts enabled cycles and flags
// the cycle in which the count reaches LAST.
module pc_sequencer_fetch_timer
   import pc_sequencer_pkg::*;
#(
   parameter logic [TIMER_W-1:0] LAST = {TIMER_W{1'b1}} - {{(TIMER_W-1){1'b0}}, 1'b1}
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [TIMER_W-1:0] count_r;

   // cycle counter, zeroed whenever the sequencer is not fetching
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (clear) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (enable) begin
         count_r <= count_r + {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign expire = enable && (count_r == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: fetches one instruction, hands it to decode, waits for
// branch resolution and commits PC+4, the redirect target or the trap vector.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC      = 32'h0000_0100,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        stall,
   input  logic        br_valid,
   input  logic        br_taken,
   input  logic [31:0] targetAddr,
   output logic [31:0] PC,
   output logic [31:0] pc_plus4,
   output logic        fetch_err,
   output logic        misalign_err
);

   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(FETCH_TIMEOUT - 32'd1);

   pcsState_e   state_r;
   pcsState_e   stateNext_s;
   logic [31:0] pc_r;
   logic [31:0] pcNext_s;
   logic [31:0] pcPlus4_s;
   logic [31:0] inst_r;
   logic        instLoad_s;
   logic        instValid_r;
   logic        instValidNext_s;
   logic        fetchErr_r;
   logic        fetchErrNext_s;
   logic        misalignErr_r;
   logic        misalignErrNext_s;
   logic        armed_r;
   logic        fetchActive_s;
   logic        timerExpire_s;

   // The request is held off for one cycle after reset release via armed_r.
   assign fetchActive_s = (state_r == PCS_FETCH) && armed_r;
   assign pcPlus4_s     = pc_r + PC_STEP;

   pc_sequencer_fetch_timer #(
      .LAST (TIMER_LAST)
   ) u_fetchTimer (
      .clk    (clk),
      .rst    (rst),
      .clear  (!fetchActive_s),
      .enable (fetchActive_s),
      .expire (timerExpire_s)
   );

   // next-state, next-PC and output-update decisions
   always_comb begin
      stateNext_s       = state_r;
      pcNext_s          = pc_r;
      instLoad_s        = 1'b0;
      instValidNext_s   = instValid_r;
      fetchErrNext_s    = 1'b0;
      misalignErrNext_s = 1'b0;
      case (state_r)
         PCS_FETCH: begin
            if (fetchActive_s && imem_ack) begin
               instLoad_s      = 1'b1;
               instValidNext_s = 1'b1;
               stateNext_s     = PCS_ISSUE;
            end else if (timerExpire_s) begin
               fetchErrNext_s = 1'b1;
               stateNext_s    = PCS_TRAP;
            end else begin
               stateNext_s = PCS_FETCH;
            end
         end
         PCS_ISSUE: begin
            if (inst_ready && !stall) begin
               instValidNext_s = 1'b0;
               stateNext_s     = PCS_RESOLVE;
            end else begin
               stateNext_s = PCS_ISSUE;
            end
         end
         PCS_RESOLVE: begin
            if (br_valid && !stall) begin
               if (!br_taken) begin
                  pcNext_s    = pcPlus4_s;
                  stateNext_s = PCS_FETCH;
               end else if (isWordAligned(targetAddr)) begin
                  pcNext_s    = targetAddr;
                  stateNext_s = PCS_FETCH;
               end else begin
                  misalignErrNext_s = 1'b1;
                  stateNext_s       = PCS_TRAP;
               end
            end else begin
               stateNext_s = PCS_RESOLVE;
            end
         end
         PCS_TRAP: begin
            pcNext_s    = TRAP_VEC;
            stateNext_s = PCS_FETCH;
         end
         default: begin
            pcNext_s    = pc_r;
            stateNext_s = PCS_FETCH;
         end
      endcase
   end

   // state, PC and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= PCS_FETCH;
         pc_r          <= RESET_PC;
         inst_r        <= 32'h0000_0000;
         instValid_r   <= 1'b0;
         fetchErr_r    <= 1'b0;
         misalignErr_r <= 1'b0;
         armed_r       <= 1'b0;
      end else begin
         state_r       <= stateNext_s;
         pc_r          <= pcNext_s;
         instValid_r   <= instValidNext_s;
         fetchErr_r    <= fetchErrNext_s;
         misalignErr_r <= misalignErrNext_s;
         armed_r       <= 1'b1;
         if (instLoad_s) begin
            inst_r <= imem_rdata;
         end else begin
            inst_r <= inst_r;
         end
      end
   end

   assign imem_req     = fetchActive_s;
   assign imem_addr    = pc_r;
   assign PC           = pc_r;
   assign pc_plus4     = pcPlus4_s;
   assign inst         = inst_r;
   assign inst_valid   = instValid_r;
   assign fetch_err    = fetchErr_r;
   assign misalign_err = misalignErr_r;

endmodule
